// File: rtl/gpio_pkg.sv
// Shared register map, window geometry and per-pin control bundle for the GPIO bank.
package gpio_pkg;

    localparam logic [5:0] GPIO_DIR_CLR    = 6'h00;
    localparam logic [5:0] GPIO_DIR_SET    = 6'h04;
    localparam logic [5:0] GPIO_TRI_CLR    = 6'h08;
    localparam logic [5:0] GPIO_TRI_SET    = 6'h0C;
    localparam logic [5:0] GPIO_OUT_CLR    = 6'h10;
    localparam logic [5:0] GPIO_OUT_SET    = 6'h14;
    localparam logic [5:0] GPIO_RISE_EN    = 6'h18;
    localparam logic [5:0] GPIO_FALL_EN    = 6'h1C;
    localparam logic [5:0] GPIO_IN         = 6'h20;
    localparam logic [5:0] GPIO_IRQ_STATUS = 6'h24;

    localparam int unsigned GPIO_WIN_SIZE = 64;

    typedef struct packed {
        logic dir;
        logic tri_en;
        logic out;
        logic rise_en;
        logic fall_en;
    } gpio_pin_ctrl_t;

endpackage

// File: rtl/gpio_pin_filter.sv
// One pin's 2-flop synchroniser plus optional debounce (GPIO_DEBOUNCE_EN); f_o lags the pin by
// 2 edges, plus DEB_CYCLES when debouncing. No backpressure.
module gpio_pin_filter #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pin_i,
    output logic f_o
);

    logic meta_q, sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned    CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          f_q, f_d;

    // A mismatch must persist for DEB_CYCLES consecutive cycles before f follows it.
    always_comb begin
        f_d   = f_q;
        cnt_d = '0;
        if (sync_q != f_q) begin
            if (cnt_q == CNT_LAST) begin
                f_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            f_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            f_q   <= f_d;
        end
    end

    assign f_o = f_q;
`else
    logic unused_deb;
    assign unused_deb = ^DEB_CYCLES;
    assign f_o        = sync_q;
`endif

endmodule

// File: rtl/gpio_irq_n.sv
// BW-pin GPIO bank with tristate/open-drain drive and W1C edge interrupts (debounce: GPIO_DEBOUNCE_EN).
// Writes commit one edge after capture, reads return registered data next cycle; never stalls.
module gpio_irq_n
    import gpio_pkg::*;
#(
    parameter int unsigned BW         = 8,
    parameter logic [31:0] BASE       = 32'h0000_0440,
    parameter logic [31:0] OFFSET     = 32'h0000_0040 * 0,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    inout  wire  [BW-1:0] bw_data_io,
    input  logic          ic0_c_axi_mst_wr_valid,
    input  logic [31:0]   ic0_axi_mst_wr_addr,
    input  logic [31:0]   ic0_axi_mst_wr_data,
    input  logic          ic0_c_axi_mst_rd_valid,
    input  logic [31:0]   ic0_axi_mst_rd_addr,
    output logic          ic0_c_axi_slv_rd_ready_0,
    output logic [31:0]   ic0_axi_slv_rd_data_0,
    output logic          irq_o
);

    localparam int unsigned WB       = $clog2(GPIO_WIN_SIZE);
    localparam logic [31:0] WIN_ADDR = BASE + OFFSET;

    logic          wr_vld_q;
    logic [5:0]    wr_off_q;
    logic [BW-1:0] wr_dat_q;
    logic [BW-1:0] dir_q, dir_d, tri_q, tri_d, out_q, out_d;
    logic [BW-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [BW-1:0] status_q, status_d, prev_q;
    logic [BW-1:0] in_f, rise_evt, fall_evt, w1c, rd_sel;
    logic          wr_hit, rd_hit, irq_q, rd_rdy_q;
    logic [31:0]   rd_dat_q, rd_dat_d;
    logic          unused_bits;

    assign wr_hit = ic0_c_axi_mst_wr_valid && (ic0_axi_mst_wr_addr[11:WB] == WIN_ADDR[11:WB]);
    assign rd_hit = ic0_c_axi_mst_rd_valid && (ic0_axi_mst_rd_addr[11:WB] == WIN_ADDR[11:WB]);
    assign unused_bits = ^{ic0_axi_mst_wr_addr[31:12], ic0_axi_mst_rd_addr[31:12], ic0_axi_mst_wr_data};

    for (genvar i = 0; i < BW; i++) begin : g_pin
        gpio_pin_ctrl_t ctrl;
        assign ctrl = '{dir: dir_q[i], tri_en: tri_q[i], out: out_q[i],
                        rise_en: rise_en_q[i], fall_en: fall_en_q[i]};
        // Open-drain mode only ever pulls low; a '1' releases the pin.
        assign bw_data_io[i] = (ctrl.dir && !(ctrl.tri_en && ctrl.out)) ? ctrl.out : 1'bz;
        assign rise_evt[i]   = ctrl.rise_en &  in_f[i] & ~prev_q[i];
        assign fall_evt[i]   = ctrl.fall_en & ~in_f[i] &  prev_q[i];

        gpio_pin_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .pin_i   (bw_data_io[i]),
            .f_o     (in_f[i])
        );
    end

    always_comb begin
        dir_d     = dir_q;
        tri_d     = tri_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr_vld_q) begin
            case (wr_off_q)
                GPIO_DIR_CLR:    dir_d     = dir_q & ~wr_dat_q;
                GPIO_DIR_SET:    dir_d     = dir_q | wr_dat_q;
                GPIO_TRI_CLR:    tri_d     = tri_q & ~wr_dat_q;
                GPIO_TRI_SET:    tri_d     = tri_q | wr_dat_q;
                GPIO_OUT_CLR:    out_d     = out_q & ~wr_dat_q;
                GPIO_OUT_SET:    out_d     = out_q | wr_dat_q;
                GPIO_RISE_EN:    rise_en_d = wr_dat_q;
                GPIO_FALL_EN:    fall_en_d = wr_dat_q;
                GPIO_IRQ_STATUS: w1c       = wr_dat_q;
                default: ;
            endcase
        end
        // New events are OR-ed in after the clear so a coincident edge is never lost.
        status_d = (status_q & ~w1c) | rise_evt | fall_evt;
    end

    always_comb begin
        rd_sel = '0;
        case (ic0_axi_mst_rd_addr[5:0])
            GPIO_DIR_SET:    rd_sel = dir_q;
            GPIO_TRI_SET:    rd_sel = tri_q;
            GPIO_OUT_SET:    rd_sel = out_q;
            GPIO_RISE_EN:    rd_sel = rise_en_q;
            GPIO_FALL_EN:    rd_sel = fall_en_q;
            GPIO_IN:         rd_sel = in_f;
            GPIO_IRQ_STATUS: rd_sel = status_q;
            default: ;
        endcase
        rd_dat_d = rd_hit ? 32'(rd_sel) : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_q  <= 1'b0;
            wr_off_q  <= '0;
            wr_dat_q  <= '0;
            dir_q     <= '0;
            tri_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
            rd_rdy_q  <= 1'b0;
            rd_dat_q  <= '0;
        end else begin
            wr_vld_q  <= wr_hit;
            wr_off_q  <= ic0_axi_mst_wr_addr[5:0];
            wr_dat_q  <= ic0_axi_mst_wr_data[BW-1:0];
            dir_q     <= dir_d;
            tri_q     <= tri_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= in_f;
            irq_q     <= |status_q;
            rd_rdy_q  <= rd_hit;
            rd_dat_q  <= rd_dat_d;
        end
    end

    assign ic0_c_axi_slv_rd_ready_0 = rd_rdy_q;
    assign ic0_axi_slv_rd_data_0    = rd_dat_q;
    assign irq_o                    = irq_q;

endmodule

// File: tb/tb_gpio_irq_n.sv
// Directed bench for gpio_irq_n: register access, pin drive modes, edge interrupts and W1C races.
module tb_gpio_irq_n;

    localparam int          BW = 8;
    localparam logic [31:0] A  = 32'h0000_0440;
`ifdef GPIO_DEBOUNCE_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    wire  [7:0]  pins;
    logic [7:0]  drv_en = '0;
    logic [7:0]  drv_val = '0;
    logic        wr_vld = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_vld = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_rdy;
    logic [31:0] rd_data;
    logic        irq;
    int          n_chk = 0;
    int          n_bad = 0;

    for (genvar i = 0; i < BW; i++) begin : g_tb_pin
        assign pins[i] = drv_en[i] ? drv_val[i] : 1'bz;
        pullup pu (pins[i]);
    end

    gpio_irq_n #(
        .BW         (BW),
        .BASE       (32'h0000_0440),
        .OFFSET     (32'h0000_0000),
        .DEB_CYCLES (4)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .bw_data_io               (pins),
        .ic0_c_axi_mst_wr_valid   (wr_vld),
        .ic0_axi_mst_wr_addr      (wr_addr),
        .ic0_axi_mst_wr_data      (wr_data),
        .ic0_c_axi_mst_rd_valid   (rd_vld),
        .ic0_axi_mst_rd_addr      (rd_addr),
        .ic0_c_axi_slv_rd_ready_0 (rd_rdy),
        .ic0_axi_slv_rd_data_0    (rd_data),
        .irq_o                    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns at the negedge after the commit edge, so the write is already visible.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); wr_vld = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk); wr_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic exp_rdy, input logic [31:0] exp);
        @(negedge clk); rd_vld = 1'b1; rd_addr = a;
        @(negedge clk); rd_vld = 1'b0;
        check({tag, ".rdy"}, 32'(rd_rdy), 32'(exp_rdy));
        check(tag, rd_data, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rdy", 32'(rd_rdy), 32'h0);
        check("rst_rdat", rd_data, 32'h0);
        check("rst_pins", 32'(pins), 32'hFF);
        rst_n = 1'b1;

        rd("dir0", A + 32'h04, 1'b1, 32'h0);
        rd("tri0", A + 32'h0C, 1'b1, 32'h0);
        rd("out0", A + 32'h14, 1'b1, 32'h0);
        rd("sts0", A + 32'h24, 1'b1, 32'h0);
        @(negedge clk);
        check("rdy_one_cycle", 32'(rd_rdy), 32'h0);
        check("irq0", 32'(irq), 32'h0);

        wr(A + 32'h04, 32'hFF);
        wr(A + 32'h14, 32'hA5);
        check("pins_a5", 32'(pins), 32'hA5);
        rd("dir_ff", A + 32'h04, 1'b1, 32'hFF);
        rd("out_a5", A + 32'h14, 1'b1, 32'hA5);

        @(negedge clk); wr_vld = 1'b1; wr_addr = A + 32'h10; wr_data = 32'h05;
        @(negedge clk); wr_vld = 1'b0;
        check("pins_hold", 32'(pins), 32'hA5);
        @(negedge clk);
        check("pins_a0", 32'(pins), 32'hA0);

        // Open-drain on pin 0: out=1 releases, out=0 pulls low.
        wr(A + 32'h14, 32'h01);
        check("pins_a1", 32'(pins), 32'hA1);
        wr(A + 32'h0C, 32'h01);
        rd("tri_1", A + 32'h0C, 1'b1, 32'h01);
        drv_en[0] = 1'b1; drv_val[0] = 1'b0;
        @(negedge clk);
        check("pin0_released", 32'(pins), 32'hA0);
        drv_en[0] = 1'b0;
        @(negedge clk);
        check("pin0_pullup", 32'(pins), 32'hA1);
        wr(A + 32'h10, 32'h01);
        check("pin0_od_low", 32'(pins), 32'hA0);

        // Hand pin 1 to the bench and arm its rising-edge interrupt.
        drv_val[1] = 1'b0; drv_en[1] = 1'b1;
        wr(A + 32'h00, 32'h02);
        repeat (12) @(negedge clk);
        wr(A + 32'h18, 32'h02);
        rd("rise_en", A + 32'h18, 1'b1, 32'h02);
        rd("in_a0", A + 32'h20, 1'b1, 32'hA0);
        @(negedge clk); drv_val[1] = 1'b1;
        repeat (3 + EXTRA) @(negedge clk);
        check("irq_early", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'h1);
        rd("sts_rise", A + 32'h24, 1'b1, 32'h02);
        wr(A + 32'h24, 32'h02);
        check("irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_clr", 32'(irq), 32'h0);
        rd("sts_clr", A + 32'h24, 1'b1, 32'h0);

        // Rising edge lands on the same commit edge as a W1C of the same bit.
        drv_val[1] = 1'b0;
        repeat (8 + 2 * EXTRA) @(negedge clk);
        @(negedge clk); drv_val[1] = 1'b1;
        repeat (1 + EXTRA) @(negedge clk);
        wr_vld = 1'b1; wr_addr = A + 32'h24; wr_data = 32'h02;
        @(negedge clk); wr_vld = 1'b0;
        @(negedge clk);
        rd("sts_race", A + 32'h24, 1'b1, 32'h02);
        check("irq_race", 32'(irq), 32'h1);

        wr(A + 32'h24, 32'hFF);
        wr(A + 32'h18, 32'h00);
        wr(A + 32'h1C, 32'h02);
        rd("fall_en", A + 32'h1C, 1'b1, 32'h02);
        check("irq_fall_idle", 32'(irq), 32'h0);
        drv_val[1] = 1'b0;
        repeat (6 + EXTRA) @(negedge clk);
        rd("sts_fall", A + 32'h24, 1'b1, 32'h02);

        rd("out_of_win", 32'h0000_0480, 1'b0, 32'h0);
        rd("unmapped", A + 32'h3C, 1'b1, 32'h0);
        wr(32'h0000_0494, 32'hFF);
        rd("out_keep", A + 32'h14, 1'b1, 32'hA0);
        rd("in_now", A + 32'h20, 1'b1, 32'hA0);

`ifdef GPIO_DEBOUNCE_EN
        wr(A + 32'h24, 32'hFF);
        @(negedge clk); drv_val[1] = 1'b1;
        repeat (3) @(negedge clk); drv_val[1] = 1'b0;
        repeat (12) @(negedge clk);
        rd("glitch_in", A + 32'h20, 1'b1, 32'hA0);
        rd("glitch_sts", A + 32'h24, 1'b1, 32'h0);

        @(negedge clk); drv_val[1] = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk); drv_val[1] = 1'b0; rd_vld = 1'b1; rd_addr = A + 32'h20;
        @(negedge clk);
        check("deb_old", rd_data, 32'hA0);
        @(negedge clk); rd_vld = 1'b0;
        check("deb_new", rd_data, 32'hA2);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
